// File: rtl/pin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pin_pkg
//  Description : Shared types and helpers for the GPIO pin gather/decompress
//                paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } gather_state_t;

    // Width of a popcount over 'width' bits (must represent 0..width).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : pin_pkg
`default_nettype wire

// File: rtl/pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pin_sync
//  Description : WIDTH-bit multi-stage synchronizer for asynchronous pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module pin_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_pins
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_pins;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_pins = r_stage[SYNC_STAGES-1];

endmodule : pin_sync
`default_nettype wire

// File: rtl/pin_gather.sv
`default_nettype none
// ============================================================================
//  Module      : pin_gather
//  Description : Sequential bit-gather engine: packs mask-selected pins into
//                the low bits of a result word, one bit position per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pin_gather
    import pin_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             pins_in,
    input  logic [WIDTH-1:0]             mask,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = cnt_width(WIDTH);

    gather_state_t      r_state;
    gather_state_t      w_state_nxt;

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   r_snap_sr;
    logic [WIDTH-1:0]   r_mask_sr;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_result;
    logic [CW-1:0]      r_count;

    logic               w_take;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mask_shift;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [CW-1:0]      w_idx_nxt;

    pin_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pins (pins_in),
        .o_pins (w_sync)
    );

    assign w_take       = r_mask_sr[0];
    assign w_accept     = (r_state == IDLE) && start;
    assign w_mask_shift = r_mask_sr >> 1;
    assign w_last       = (w_mask_shift == '0);
    assign w_idx_nxt    = r_idx + {{(CW-1){1'b0}}, w_take};

    // Index compare instead of a variable bit-select keeps the write in range.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_take && (r_idx == CW'(k))) begin
                w_acc_nxt[k] = r_snap_sr[0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SCAN;
            SCAN:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_sr <= '0;
            r_mask_sr <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_result  <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_snap_sr <= w_sync;
            r_mask_sr <= mask;
            r_acc     <= '0;
            r_idx     <= '0;
        end else if (r_state == SCAN) begin
            r_acc     <= w_acc_nxt;
            r_idx     <= w_idx_nxt;
            r_mask_sr <= w_mask_shift;
            r_snap_sr <= r_snap_sr >> 1;
            if (w_last) begin
                r_result <= w_acc_nxt;
                r_count  <= w_idx_nxt;
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign count  = r_count;

endmodule : pin_gather
`default_nettype wire

// File: tb/tb_pin_gather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pin_gather
//  Description : Directed self-checking bench for pin_gather.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_gather;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] pins_in;
    logic [WIDTH-1:0] mask;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    pin_gather #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pins_in (pins_in),
        .mask    (mask),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples a fixed window after the accepting edge; index 0 is the first SCAN cycle.
    task automatic observe(input int cycles, output int bc, output int dc, output int da,
                           output logic [WIDTH-1:0] res, output logic [CW-1:0] cnt);
        bc = 0; dc = 0; da = -1; res = '0; cnt = '0;
        for (int i = 0; i < cycles; i++) begin
            if (busy) bc++;
            if (done) begin
                dc++; da = i; res = result; cnt = count;
            end
            tick();
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        pins_in = p; mask = m;
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pins_in = '0; mask = '0;
        tick(); tick();
        n_checks += 4;
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        if (result !== '0)    begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
        if (count !== '0)     begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        launch(16'b0000000100000101, 16'b0101000101000101);
        observe(30, bc, dc, da, res, cnt);
        n_checks += 5;
        if (bc !== 16)          begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
        if (dc !== 1)           begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", dc); end
        if (da !== 15)          begin n_fail++; $display("FAIL basic_done_at got=%0d exp=15", da); end
        if (res !== 16'h000B)   begin n_fail++; $display("FAIL basic_result got=%h exp=000b", res); end
        if (cnt !== 5'd6)       begin n_fail++; $display("FAIL basic_count got=%0d exp=6", cnt); end
    endtask

    task automatic test_zero_mask();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        launch(16'hFFFF, 16'h0000);
        observe(8, bc, dc, da, res, cnt);
        n_checks += 5;
        if (bc !== 2)           begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=2", bc); end
        if (dc !== 1)           begin n_fail++; $display("FAIL zero_done_pulses got=%0d exp=1", dc); end
        if (da !== 1)           begin n_fail++; $display("FAIL zero_done_at got=%0d exp=1", da); end
        if (res !== 16'h0000)   begin n_fail++; $display("FAIL zero_result got=%h exp=0000", res); end
        if (cnt !== 5'd0)       begin n_fail++; $display("FAIL zero_count got=%0d exp=0", cnt); end
    endtask

    task automatic test_full_mask();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        launch(16'hA5C3, 16'hFFFF);
        observe(24, bc, dc, da, res, cnt);
        n_checks += 5;
        if (bc !== 17)          begin n_fail++; $display("FAIL full_busy_cycles got=%0d exp=17", bc); end
        if (dc !== 1)           begin n_fail++; $display("FAIL full_done_pulses got=%0d exp=1", dc); end
        if (da !== 16)          begin n_fail++; $display("FAIL full_done_at got=%0d exp=16", da); end
        if (res !== 16'hA5C3)   begin n_fail++; $display("FAIL full_result got=%h exp=a5c3", res); end
        if (cnt !== 5'd16)      begin n_fail++; $display("FAIL full_count got=%0d exp=16", cnt); end
    endtask

    task automatic test_busy_isolation();
        int bc = 0, dc = 0;
        logic [WIDTH-1:0] res = '0; logic [CW-1:0] cnt = '0;
        launch(16'h00A0, 16'h00F0);
        mask = 16'hFFFF; pins_in = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if (busy) bc++;
            start = (i == 3);
            if (done) begin
                dc++; res = result; cnt = count;
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        n_checks += 4;
        if (bc !== 9)           begin n_fail++; $display("FAIL iso_busy_cycles got=%0d exp=9", bc); end
        if (dc !== 1)           begin n_fail++; $display("FAIL iso_done_pulses got=%0d exp=1", dc); end
        if (res !== 16'h000A)   begin n_fail++; $display("FAIL iso_result got=%h exp=000a", res); end
        if (cnt !== 5'd4)       begin n_fail++; $display("FAIL iso_count got=%0d exp=4", cnt); end
    endtask

    task automatic test_restart();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        logic seen = 1'b0;
        launch(16'h0003, 16'h0003);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        n_checks += 1;
        if (!seen) begin n_fail++; $display("FAIL restart_first_done got=timeout exp=done"); end
        n_checks += 2;
        if (result !== 16'h0003) begin n_fail++; $display("FAIL restart_first_result got=%h exp=0003", result); end
        if (count !== 5'd2)      begin n_fail++; $display("FAIL restart_first_count got=%0d exp=2", count); end
        tick();
        n_checks += 1;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle got=%b exp=0", busy); end
        mask = 16'h0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks += 1;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_accept got=%b exp=1", busy); end
        observe(8, bc, dc, da, res, cnt);
        n_checks += 3;
        if (dc !== 1)           begin n_fail++; $display("FAIL restart_done_pulses got=%0d exp=1", dc); end
        if (res !== 16'h0001)   begin n_fail++; $display("FAIL restart_result got=%h exp=0001", res); end
        if (cnt !== 5'd1)       begin n_fail++; $display("FAIL restart_count got=%0d exp=1", cnt); end
    endtask

    task automatic test_sync_latency();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        pins_in = '0; mask = 16'h0001;
        tick(); tick(); tick(); tick();
        pins_in = 16'h0001;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        observe(6, bc, dc, da, res, cnt);
        n_checks += 2;
        if (dc !== 1)           begin n_fail++; $display("FAIL sync_early_done got=%0d exp=1", dc); end
        if (res !== 16'h0000)   begin n_fail++; $display("FAIL sync_early_result got=%h exp=0000", res); end
        pins_in = '0;
        tick(); tick(); tick(); tick();
        pins_in = 16'h0001;
        for (int k = 0; k < SYNC; k++) tick();
        start = 1'b1; tick(); start = 1'b0;
        observe(6, bc, dc, da, res, cnt);
        n_checks += 2;
        if (dc !== 1)           begin n_fail++; $display("FAIL sync_late_done got=%0d exp=1", dc); end
        if (res !== 16'h0001)   begin n_fail++; $display("FAIL sync_late_result got=%h exp=0001", res); end
    endtask

    task automatic test_reset_midscan();
        int bc, dc, da; logic [WIDTH-1:0] res; logic [CW-1:0] cnt;
        launch(16'hFFFF, 16'hFFFF);
        tick(); tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (result !== '0)    begin n_fail++; $display("FAIL midrst_result got=%h exp=0000", result); end
        if (count !== '0)     begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", count); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        observe(20, bc, dc, da, res, cnt);
        n_checks += 2;
        if (dc !== 0)         begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dc); end
        if (bc !== 0)         begin n_fail++; $display("FAIL midrst_idle got=%0d exp=0", bc); end
        launch(16'hFFFF, 16'h0001);
        observe(6, bc, dc, da, res, cnt);
        n_checks += 2;
        if (dc !== 1)           begin n_fail++; $display("FAIL midrst_resume_done got=%0d exp=1", dc); end
        if (res !== 16'h0001)   begin n_fail++; $display("FAIL midrst_resume_result got=%h exp=0001", res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_mask();
        test_full_mask();
        test_busy_isolation();
        test_restart();
        test_sync_latency();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pin_gather
`default_nettype wire
